// File: rtl/kanagawa_hal_fifo_write_arbiter.sv
// Round-robin arbiter sharing one KanagawaHALDualClockFifo write port among NUM_REQ requesters.
// Define KANAGAWA_FIFO_ARB_PKT_LOCK_EN to keep multi-beat packets contiguous (IDLE/LOCKED FSM).
module kanagawa_hal_fifo_write_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]       req_last,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic                     fifo_almost_full,
   output logic                     fifo_wrreq,
   output logic [WIDTH-1:0]         fifo_data,
   output logic                     fifo_last,
   output logic [SRC_W-1:0]         fifo_src
);

   // Index arithmetic modulo NUM_REQ, which need not be a power of two.
   function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return sum[SRC_W-1:0];
   endfunction

   logic             armed;
   logic [SRC_W-1:0] rr_ptr;
   logic [SRC_W-1:0] winner;
   logic             winner_found;
   logic [SRC_W-1:0] sel;
   logic             sel_valid;
   logic             sel_last;
   logic [WIDTH-1:0] sel_data;
   logic             grant_en;
   logic             grant_ok;
   logic             accept;
   logic             ptr_adv;

   // Readiness follows reset release by one edge so nothing is accepted mid-reset-release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) armed <= 1'b0;
      else        armed <= 1'b1;
   end

   assign grant_en = armed & ~fifo_almost_full;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      winner       = '0;
      winner_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!winner_found && req_valid[wrap_add(rr_ptr, k)]) begin
            winner_found = 1'b1;
            winner       = wrap_add(rr_ptr, k);
         end
      end
   end

`ifdef KANAGAWA_FIFO_ARB_PKT_LOCK_EN
   typedef enum logic {IDLE, LOCKED} state_t;

   state_t           state, state_next;
   logic [SRC_W-1:0] owner, owner_next;

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         owner <= '0;
      end else begin
         state <= state_next;
         owner <= owner_next;
      end
   end

   // The owner keeps the grant until its last beat, even across bubbles or almost_full stalls.
   assign sel      = (state == LOCKED) ? owner : winner;
   assign grant_ok = (state == LOCKED) | winner_found;

   always_comb begin
      state_next = state;
      owner_next = owner;
      ptr_adv    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (sel_last) begin
                  ptr_adv = 1'b1;
               end else begin
                  state_next = LOCKED;
                  owner_next = winner;
               end
            end
         end
         LOCKED: begin
            if (accept && sel_last) begin
               state_next = IDLE;
               ptr_adv    = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end
`else
   // Without packet lock every accepted beat re-arbitrates.
   assign sel      = winner;
   assign grant_ok = winner_found;
   assign ptr_adv  = accept;
`endif

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel == SRC_W'(i)) begin
            sel_valid    = req_valid[i];
            sel_last     = req_last[i];
            sel_data     = req_data[i*WIDTH +: WIDTH];
            req_ready[i] = grant_en & grant_ok;
         end
      end
   end

   assign accept = grant_en & grant_ok & sel_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       rr_ptr <= '0;
      else if (ptr_adv) rr_ptr <= wrap_add(sel, 1);
   end

   // Push registers: the payload holds between pushes, wrreq pulses once per accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_wrreq <= 1'b0;
         fifo_data  <= '0;
         fifo_last  <= 1'b0;
         fifo_src   <= '0;
      end else begin
         fifo_wrreq <= accept;
         if (accept) begin
            fifo_data <= sel_data;
            fifo_last <= sel_last;
            fifo_src  <= sel;
         end
      end
   end

   a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
   a_af_stalls    : assert property (@(posedge clk) disable iff (!rst_n)
                                     fifo_almost_full |-> (req_ready == '0));
   a_ptr_range    : assert property (@(posedge clk) disable iff (!rst_n) int'(rr_ptr) < NUM_REQ);

endmodule

// File: tb/tb_kanagawa_hal_fifo_write_arbiter.sv
// Scoreboard bench for kanagawa_hal_fifo_write_arbiter (4-requester and 3-requester instances).
module tb_kanagawa_hal_fifo_write_arbiter;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int SW = 2;
   localparam int W3 = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]   req_valid, req_last, req_ready;
   logic [N*W-1:0] req_data;
   logic           af;
   logic           fifo_wrreq, fifo_last;
   logic [W-1:0]   fifo_data;
   logic [SW-1:0]  fifo_src;

   logic [2:0]      v3, l3, r3;
   logic [3*W3-1:0] d3;
   logic            af3 = 1'b0;
   logic            wr3, fl3;
   logic [W3-1:0]   fd3;
   logic [1:0]      fs3;

   kanagawa_hal_fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .fifo_almost_full(af), .fifo_wrreq(fifo_wrreq),
      .fifo_data(fifo_data), .fifo_last(fifo_last), .fifo_src(fifo_src));

   kanagawa_hal_fifo_write_arbiter #(.NUM_REQ(3), .WIDTH(W3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_data(d3), .req_last(l3),
      .req_ready(r3), .fifo_almost_full(af3), .fifo_wrreq(wr3),
      .fifo_data(fd3), .fifo_last(fl3), .fifo_src(fs3));

   typedef struct {
      logic [SW-1:0] src;
      logic [W-1:0]  data;
      logic          last;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   beats_left[N], pkt_len[N], beat_idx[N], seq[N];
   int   cyc, wr_count, first_wr, last_wr;

   // Requester i sends payload {i, per-requester sequence number}.
   task automatic apply_reqs();
      for (int i = 0; i < N; i++) begin
         req_valid[i]         = beats_left[i] > 0;
         req_last[i]          = beat_idx[i] == pkt_len[i] - 1;
         req_data[i*W +: W]   = {8'(i), 24'(seq[i])};
      end
   endtask

   task automatic push_exp(input int src, input int s, input logic last);
      exp_t e;
      e.src  = SW'(src);
      e.data = {8'(src), 24'(s)};
      e.last = last;
      exp_q.push_back(e);
   endtask

   // One clock: handshake sampled before the edge, outputs scored after the falling edge.
   task automatic advance();
      logic [N-1:0] acc;
      exp_t         e;
      #1;
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            seq[i]        = seq[i] + 1;
            beats_left[i] = beats_left[i] - 1;
            beat_idx[i]   = (beat_idx[i] + 1 == pkt_len[i]) ? 0 : beat_idx[i] + 1;
         end
      end
      apply_reqs();
      @(negedge clk);
      #1;
      cyc = cyc + 1;
      if (fifo_wrreq === 1'b1) begin
         wr_count = wr_count + 1;
         if (first_wr < 0) first_wr = cyc;
         last_wr = cyc;
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL push_unexpected: got src=%0d data=%h last=%0d, required no push",
                     fifo_src, fifo_data, fifo_last);
         end else begin
            e = exp_q.pop_front();
            if (fifo_src !== e.src || fifo_data !== e.data || fifo_last !== e.last) begin
               errors = errors + 1;
               $display("FAIL push_beat: got src=%0d data=%h last=%0d, required src=%0d data=%h last=%0d",
                        fifo_src, fifo_data, fifo_last, e.src, e.data, e.last);
            end
         end
      end
   endtask

   task automatic run_until_empty(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         advance();
         n = n + 1;
      end
      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL %s_timeout: %0d beats still expected after %0d cycles, required 0",
                  name, exp_q.size(), budget);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      af    = 1'b0;
      for (int i = 0; i < N; i++) begin
         beats_left[i] = 0;
         pkt_len[i]    = 1;
         beat_idx[i]   = 0;
         seq[i]        = 0;
      end
      apply_reqs();
      v3 = '0;
      l3 = '0;
      d3 = '0;
      exp_q.delete();
      cyc      = 0;
      wr_count = 0;
      first_wr = -1;
      last_wr  = -1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < N; i++) beats_left[i] = 2;
      apply_reqs();
      #1;
      checks = checks + 5;
      if (fifo_wrreq !== 1'b0) begin errors++; $display("FAIL rst_wrreq: got %b, required 0", fifo_wrreq); end
      if (fifo_data !== '0)    begin errors++; $display("FAIL rst_data: got %h, required 0", fifo_data); end
      if (fifo_last !== 1'b0)  begin errors++; $display("FAIL rst_last: got %b, required 0", fifo_last); end
      if (fifo_src !== '0)     begin errors++; $display("FAIL rst_src: got %0d, required 0", fifo_src); end
      if (req_ready !== '0)    begin errors++; $display("FAIL rst_ready: got %b, required 0000", req_ready); end
      rst_n = 1'b1;
      #1;
      checks = checks + 1;
      if (req_ready !== 4'b0000) begin
         errors++; $display("FAIL unarmed_ready: got %b, required 0000", req_ready);
      end
      advance();
      checks = checks + 2;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL armed_ready: got %b, required 0001", req_ready);
      end
      if (fifo_wrreq !== 1'b0) begin
         errors++; $display("FAIL armed_wrreq: got %b, required 0", fifo_wrreq);
      end
   endtask

   task automatic test_round_robin();
      for (int i = 0; i < 8; i++) push_exp(i % 4, i / 4, 1'b1);
      run_until_empty("round_robin", 20);
      advance();
      checks = checks + 2;
      if (wr_count !== 8) begin
         errors++; $display("FAIL rr_count: got %0d pushes, required 8", wr_count);
      end
      if (last_wr - first_wr + 1 - wr_count !== 0) begin
         errors++; $display("FAIL rr_bubbles: got %0d idle cycles, required 0", last_wr - first_wr + 1 - wr_count);
      end
   endtask

   task automatic test_packet_lock();
      do_reset();
      beats_left[1] = 1;
      apply_reqs();
      rst_n = 1'b1;
      advance();
      push_exp(1, 0, 1'b1);
      run_until_empty("lock_setup", 10);
      beats_left[2] = 5;
      pkt_len[2]    = 5;
      beats_left[0] = 1;
      beats_left[1] = 1;
      beats_left[3] = 1;
      apply_reqs();
`ifdef KANAGAWA_FIFO_ARB_PKT_LOCK_EN
      for (int k = 0; k < 5; k++) push_exp(2, k, k == 4);
      push_exp(3, 0, 1'b1);
      push_exp(0, 0, 1'b1);
      push_exp(1, 1, 1'b1);
`else
      push_exp(2, 0, 1'b0);
      push_exp(3, 0, 1'b1);
      push_exp(0, 0, 1'b1);
      push_exp(1, 1, 1'b1);
      for (int k = 1; k < 5; k++) push_exp(2, k, k == 4);
`endif
      run_until_empty("lock", 40);
      checks = checks + 2;
      if (wr_count !== 9) begin
         errors++; $display("FAIL lock_count: got %0d pushes, required 9", wr_count);
      end
      if (last_wr - first_wr + 1 - wr_count !== 0) begin
         errors++; $display("FAIL lock_bubbles: got %0d idle cycles, required 0", last_wr - first_wr + 1 - wr_count);
      end
   endtask

   task automatic test_almost_full();
      do_reset();
      beats_left[0] = 6;
      pkt_len[0]    = 6;
      apply_reqs();
      for (int k = 0; k < 6; k++) push_exp(0, k, k == 5);
      rst_n = 1'b1;
      advance();
      advance();
      advance();
      af = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks = checks + 1;
         if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL af_ready: got %b, required 0000", req_ready);
         end
         advance();
      end
      af = 1'b0;
      run_until_empty("almost_full", 20);
      checks = checks + 2;
      if (wr_count !== 6) begin
         errors++; $display("FAIL af_count: got %0d pushes, required 6", wr_count);
      end
      if (last_wr - first_wr + 1 - wr_count !== 3) begin
         errors++; $display("FAIL af_stall: got %0d idle cycles, required 3", last_wr - first_wr + 1 - wr_count);
      end
   endtask

   task automatic test_wrap3();
      do_reset();
      rst_n = 1'b1;
      advance();
      v3 = 3'b010;
      l3 = 3'b111;
      d3 = {8'hA2, 8'hA1, 8'hA0};
      #1;
      checks++;
      if (r3 !== 3'b010) begin errors++; $display("FAIL wrap_ready1: got %b, required 010", r3); end
      advance();
      checks++;
      if (wr3 !== 1'b1 || fs3 !== 2'd1 || fd3 !== 8'hA1) begin
         errors++; $display("FAIL wrap_push1: got wr=%b src=%0d data=%h, required wr=1 src=1 data=a1", wr3, fs3, fd3);
      end
      v3 = 3'b101;
      #1;
      checks++;
      if (r3 !== 3'b100) begin errors++; $display("FAIL wrap_ready2: got %b, required 100", r3); end
      advance();
      checks++;
      if (wr3 !== 1'b1 || fs3 !== 2'd2 || fd3 !== 8'hA2) begin
         errors++; $display("FAIL wrap_push2: got wr=%b src=%0d data=%h, required wr=1 src=2 data=a2", wr3, fs3, fd3);
      end
      v3 = 3'b001;
      #1;
      checks++;
      if (r3 !== 3'b001) begin errors++; $display("FAIL wrap_ready3: got %b, required 001", r3); end
      advance();
      checks++;
      if (wr3 !== 1'b1 || fs3 !== 2'd0 || fd3 !== 8'hA0) begin
         errors++; $display("FAIL wrap_push3: got wr=%b src=%0d data=%h, required wr=1 src=0 data=a0", wr3, fs3, fd3);
      end
      v3 = 3'b000;
      advance();
      checks++;
      if (wr3 !== 1'b0) begin errors++; $display("FAIL wrap_idle: got wr=%b, required 0", wr3); end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      beats_left[0] = 1;
      apply_reqs();
      rst_n = 1'b1;
      advance();
      push_exp(0, 0, 1'b1);
      run_until_empty("midrst_setup", 10);
      beats_left[1] = 6;
      pkt_len[1]    = 6;
      beats_left[0] = 1;
      apply_reqs();
`ifdef KANAGAWA_FIFO_ARB_PKT_LOCK_EN
      push_exp(1, 0, 1'b0);
      push_exp(1, 1, 1'b0);
      push_exp(1, 2, 1'b0);
`else
      push_exp(1, 0, 1'b0);
      push_exp(0, 1, 1'b1);
      push_exp(1, 1, 1'b0);
`endif
      run_until_empty("midrst_pkt", 20);
      rst_n = 1'b0;
      #1;
      checks = checks + 2;
      if (fifo_wrreq !== 1'b0) begin
         errors++; $display("FAIL midrst_wrreq: got %b, required 0", fifo_wrreq);
      end
      if (req_ready !== 4'b0000) begin
         errors++; $display("FAIL midrst_ready: got %b, required 0000", req_ready);
      end
      for (int i = 0; i < N; i++) begin
         beats_left[i] = 0;
         pkt_len[i]    = 1;
         beat_idx[i]   = 0;
      end
      seq[0] = 10;
      beats_left[0] = 1;
      seq[1] = 20;
      beats_left[1] = 2;
      pkt_len[1]    = 2;
      apply_reqs();
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++; $display("FAIL rearm_ready0: got %b, required 0000", req_ready);
      end
      advance();
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL rearm_ready1: got %b, required 0001", req_ready);
      end
      push_exp(0, 10, 1'b1);
      push_exp(1, 20, 1'b0);
      push_exp(1, 21, 1'b1);
      run_until_empty("rearm", 10);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_round_robin();
      test_packet_lock();
      test_almost_full();
      test_wrap3();
      test_reset_mid_packet();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
